hls_run_ctrl: RTL and testbench
===============================

# hls_run_ctrl

Run sequencer and slave-memory arbiter for a Bambu-generated `main` accelerator. It accepts a run command and pulses `start_port` for exactly one cycle. It then counts cycles until `done_port`, with a timeout watchdog. While the accelerator is not running, it shares slave RAM channel 0 between a loader requester and a readback requester.

## Interface
Parameters:
- `ADDR_W`, default 7: per-channel slave address width.
- `DATA_W`, default 8: per-channel slave data width.
- `SIZE_W`, default 4: per-channel access-size width.
- `CNT_W`, default 32: width of the cycle counter and of the limit.

Ports:
- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `cmd_valid`, in, 1: run request.
- `cmd_limit`, in, CNT_W: timeout limit in cycles; captured when the command is accepted.
- `cmd_ready`, out, 1: command accept; high only in IDLE or DONE with the arbiter idle.
- `run_ok`, out, 1: one-cycle pulse when `done_port` is seen.
- `run_to`, out, 1: sticky; set on timeout, cleared only by reset.
- `cycles`, out, CNT_W: last run length, held until the next accept.
- `start_port`, out, 1: accelerator start.
- `done_port`, in, 1: accelerator done.
- `S_oe_ram`, out, 2.
- `S_we_ram`, out, 2.
- `S_addr_ram`, out, 2*ADDR_W.
- `S_Wdata_ram`, out, 2*DATA_W.
- `S_data_ram_size`, out, 2*SIZE_W.
- Channel 0 occupies the low slice of each S_* bus. The channel 1 slice is driven constant 0.
- `Sout_Rdata_ram`, in, 2*DATA_W.
- `Sout_DataRdy`, in, 2. Only bit 0 and the low DATA_W bits of `Sout_Rdata_ram` are used.
- `ld_req`, `ld_we`, in, 1 each.
- `ld_addr`, in, ADDR_W.
- `ld_wdata`, in, DATA_W.
- `ld_size`, in, SIZE_W.
- `ld_rdy`, out, 1.
- `ld_rdata`, out, DATA_W.
- `rb_req`, `rb_we`, `rb_addr`, `rb_wdata`, `rb_size`, `rb_rdy`, `rb_rdata`: same as the `ld_*` set, for the readback requester.

## Operation
- Run FSM states: IDLE, START, RUN, DONE, TIMEOUT.
- IDLE/DONE to START: on `cmd_valid && cmd_ready`.
  - Capture `cmd_limit` into `limit`.
  - Clear `cnt`.
  - Clear `cycles`.
- START: `start_port`=1 for this cycle only; `cnt` is set to 1.
  - If `done_port`=1 in START, go to DONE with `cycles`=1.
  - Otherwise go to RUN.
- RUN: `cnt` increments each cycle.
  - If `done_port`=1: `cycles`=`cnt`+1, pulse `run_ok`, go to DONE.
  - Else if `cnt`+1 == `limit`: set `run_to`, `cycles`=`limit`, go to TIMEOUT.
  - `done_port` has priority over timeout in the same cycle.
- `limit`=0: treated as no timeout.
- `cnt` saturates at all-ones.
- TIMEOUT: absorbing state until reset.
  - `cmd_ready`=0.
  - Arbiter grants are still allowed, for debug readback.
- Arbiter states: A_IDLE, A_ACC.
  - Grants are issued only when the run FSM is in IDLE, DONE or TIMEOUT.
  - Fixed priority: loader over readback.
  - Grant cycle: drive `S_oe_ram[0]`=!we, `S_we_ram[0]`=we, plus addr, wdata and size for exactly one cycle, then enter A_ACC.
  - A_ACC: all S_* outputs are 0. Wait for `Sout_DataRdy[0]`, then route `Sout_Rdata_ram[DATA_W-1:0]` to the granted requester's `rdata` with a one-cycle `rdy` pulse, and return to A_IDLE.
  - A requester must hold `req` and its fields stable until its `rdy`.
  - The requester deasserts `req` in the `rdy` cycle, or a new access starts in the cycle after.
- `cmd_valid` is ignored while the arbiter is in A_ACC. Arbitration is blocked from START until DONE/TIMEOUT.

## Timing
- Reset values:
  - FSM=IDLE, arbiter=A_IDLE.
  - `cmd_ready`=1.
  - `run_ok`=0, `run_to`=0, `cycles`=0.
  - `start_port`=0, all S_*=0.
  - `ld_rdy`=`rb_rdy`=0; `ld_rdata`=`rb_rdata`=0.
- Reset asserted mid-RUN or mid-A_ACC returns everything to these values immediately. A pending access is dropped and no `rdy` is issued.
- `start_port` is registered: high in the cycle after the accept edge.
- Grant latency: a `req` sampled in A_IDLE drives the S_* outputs, registered, in the next cycle.
- `rdy`/`rdata` are registered: one cycle after `Sout_DataRdy[0]`.
- Minimum access period: 3 cycles (grant, one A_ACC cycle, rdy).
- `cycles` counts from the `start_port` cycle to the `done_port` cycle inclusive.

## Structure
- Package `hls_run_ctrl_pkg`:
  - run-state and arbiter-state enums;
  - channel-slice helper constants: CH0 low-slice offsets and zero fill for channel 1.
- Sub-module `slave_port_arbiter`: the two-requester fixed-priority, single-outstanding arbiter, with an `enable` input driven by the run FSM.

## Test plan
- Reset: drive `reset`=0 mid-stream, then release. Required: all outputs at their reset values and `cmd_ready`=1.
- Normal run, `cmd_limit`=100, model asserts `done_port` 10 cycles after `start_port`. Required: a single `start_port` pulse, `run_ok` pulse, `cycles`=11, `cmd_ready`=1 in DONE.
- Timeout, `cmd_limit`=50, `done_port` never asserted. Required: `run_to`=1, `cycles`=50, `cmd_ready` stuck at 0, and a readback access still granted.
- `ld_req` and `rb_req` asserted in the same IDLE cycle. Required:
  - the loader read of addr 5 is granted first, with `S_oe_ram`=2'b01 and `S_addr_ram[6:0]`=5;
  - `ld_rdata` = the model's 0xA5;
  - the readback is granted the cycle after `ld_rdy`.
- `rb_req` raised during RUN. Required: no S_* activity until DONE, then the grant follows in the next cycle.
- `done_port` in START, and `done_port` coinciding with the limit cycle. Required: `cycles`=1 in the first case; DONE with `run_ok` and not TIMEOUT in the second.

Source files
------------

// File: rtl/hls_run_ctrl_pkg.sv
// hls_run_ctrl_pkg: state encodings and slave channel slicing constants
// shared by the run sequencer and its slave-port arbiter.
package hls_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    // A_GNT is the single cycle in which the access is driven onto channel 0
    typedef enum logic [1:0] {
        A_IDLE,
        A_GNT,
        A_ACC
    } arb_state_t;

    typedef enum logic {
        SEL_LD,
        SEL_RB
    } arb_sel_t;

    localparam int   CH0_LSB  = 0;
    localparam int   CH1_IDX  = 1;
    localparam logic CH1_FILL = 1'b0;

endpackage

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: loader/readback fixed-priority arbiter with a single
// outstanding access on slave RAM channel 0.
module slave_port_arbiter
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [SIZE_W-1:0] ld_size,
    output logic              ld_rdy,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              rb_req,
    input  logic              rb_we,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [DATA_W-1:0] rb_wdata,
    input  logic [SIZE_W-1:0] rb_size,
    output logic              rb_rdy,
    output logic [DATA_W-1:0] rb_rdata,
    output logic              m_oe,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [SIZE_W-1:0] m_size,
    input  logic              m_rdy,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    arb_sel_t          r_sel;
    logic              w_gnt_ld;
    logic              w_gnt_rb;
    logic              w_resp;
    logic              r_oe;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [SIZE_W-1:0] r_size;
    logic              r_ld_rdy;
    logic              r_rb_rdy;
    logic [DATA_W-1:0] r_ld_rdata;
    logic [DATA_W-1:0] r_rb_rdata;

    assign w_resp = (r_state == A_ACC) && m_rdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= A_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_gnt_ld = 1'b0;
        w_gnt_rb = 1'b0;
        unique case (r_state)
            A_IDLE: begin
                if (enable && ld_req) begin
                    w_gnt_ld = 1'b1;
                    w_next   = A_GNT;
                end else if (enable && rb_req) begin
                    w_gnt_rb = 1'b1;
                    w_next   = A_GNT;
                end
            end
            A_GNT:   w_next = A_ACC;
            A_ACC:   if (m_rdy) w_next = A_IDLE;
            default: w_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel      <= SEL_LD;
            r_oe       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_ld_rdy   <= 1'b0;
            r_rb_rdy   <= 1'b0;
            r_ld_rdata <= '0;
            r_rb_rdata <= '0;
        end else begin
            r_oe     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_ld_rdy <= 1'b0;
            r_rb_rdy <= 1'b0;
            if (w_gnt_ld) begin
                r_sel   <= SEL_LD;
                r_oe    <= !ld_we;
                r_we    <= ld_we;
                r_addr  <= ld_addr;
                r_wdata <= ld_wdata;
                r_size  <= ld_size;
            end else if (w_gnt_rb) begin
                r_sel   <= SEL_RB;
                r_oe    <= !rb_we;
                r_we    <= rb_we;
                r_addr  <= rb_addr;
                r_wdata <= rb_wdata;
                r_size  <= rb_size;
            end
            if (w_resp && (r_sel == SEL_RB)) begin
                r_rb_rdy   <= 1'b1;
                r_rb_rdata <= m_rdata;
            end else if (w_resp) begin
                r_ld_rdy   <= 1'b1;
                r_ld_rdata <= m_rdata;
            end
        end
    end

    assign m_oe     = r_oe;
    assign m_we     = r_we;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_size   = r_size;
    assign ld_rdy   = r_ld_rdy;
    assign ld_rdata = r_ld_rdata;
    assign rb_rdy   = r_rb_rdy;
    assign rb_rdata = r_rb_rdata;
    assign busy     = (r_state != A_IDLE);

endmodule

// File: rtl/hls_run_ctrl.sv
// hls_run_ctrl: start/done sequencer with cycle count and timeout watchdog,
// sharing slave RAM channel 0 between loader and readback while idle.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [CNT_W-1:0]    cmd_limit,
    output logic                cmd_ready,
    output logic                run_ok,
    output logic                run_to,
    output logic [CNT_W-1:0]    cycles,
    output logic                start_port,
    input  logic                done_port,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [2*DATA_W-1:0] S_Wdata_ram,
    output logic [2*SIZE_W-1:0] S_data_ram_size,
    input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy,
    input  logic                ld_req,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic [SIZE_W-1:0]   ld_size,
    output logic                ld_rdy,
    output logic [DATA_W-1:0]   ld_rdata,
    input  logic                rb_req,
    input  logic                rb_we,
    input  logic [ADDR_W-1:0]   rb_addr,
    input  logic [DATA_W-1:0]   rb_wdata,
    input  logic [SIZE_W-1:0]   rb_size,
    output logic                rb_rdy,
    output logic [DATA_W-1:0]   rb_rdata
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    run_state_t        r_state;
    run_state_t        w_next;
    logic [CNT_W-1:0]  r_limit;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_run_ok;
    logic              r_run_to;
    logic              r_start;
    logic              w_idle_like;
    logic              w_accept;
    logic              w_limit_hit;
    logic              w_arb_en;
    logic              w_arb_busy;
    logic              w_oe;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [SIZE_W-1:0] w_size;
    logic              w_mem_rdy;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_unused;

    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign cmd_ready   = w_idle_like && !w_arb_busy;
    assign w_accept    = cmd_valid && cmd_ready;
    // a same-cycle command wins over a new memory request
    assign w_arb_en    = (w_idle_like || (r_state == TIMEOUT)) && !w_accept;
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
    assign w_limit_hit = (r_limit != '0) && (w_cnt_inc == r_limit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: if (w_accept) w_next = START;
            START:      w_next = done_port ? DONE : RUN;
            RUN: begin
                if (done_port) begin
                    w_next = DONE;
                end else if (w_limit_hit) begin
                    w_next = TIMEOUT;
                end
            end
            TIMEOUT:    w_next = TIMEOUT;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_limit  <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
            r_run_ok <= 1'b0;
            r_run_to <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_run_ok <= 1'b0;
            r_start  <= w_accept;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_limit  <= cmd_limit;
                        r_cnt    <= '0;
                        r_cycles <= '0;
                    end
                end
                START: begin
                    r_cnt <= CNT_ONE;
                    if (done_port) begin
                        r_cycles <= CNT_ONE;
                        r_run_ok <= 1'b1;
                    end
                end
                RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (done_port) begin
                        r_cycles <= w_cnt_inc;
                        r_run_ok <= 1'b1;
                    end else if (w_limit_hit) begin
                        r_cycles <= r_limit;
                        r_run_to <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign run_ok     = r_run_ok;
    assign run_to     = r_run_to;
    assign cycles     = r_cycles;
    assign start_port = r_start;

    slave_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .enable   (w_arb_en),
        .ld_req   (ld_req),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_size  (ld_size),
        .ld_rdy   (ld_rdy),
        .ld_rdata (ld_rdata),
        .rb_req   (rb_req),
        .rb_we    (rb_we),
        .rb_addr  (rb_addr),
        .rb_wdata (rb_wdata),
        .rb_size  (rb_size),
        .rb_rdy   (rb_rdy),
        .rb_rdata (rb_rdata),
        .m_oe     (w_oe),
        .m_we     (w_we),
        .m_addr   (w_addr),
        .m_wdata  (w_wdata),
        .m_size   (w_size),
        .m_rdy    (w_mem_rdy),
        .m_rdata  (w_mem_rdata),
        .busy     (w_arb_busy)
    );

    assign w_mem_rdy   = Sout_DataRdy[CH0_LSB];
    assign w_mem_rdata = Sout_Rdata_ram[CH0_LSB +: DATA_W];
    assign w_unused    = ^{Sout_DataRdy[CH1_IDX],
                           Sout_Rdata_ram[CH1_IDX*DATA_W +: DATA_W]};

    assign S_oe_ram[CH0_LSB]                          = w_oe;
    assign S_oe_ram[CH1_IDX]                          = CH1_FILL;
    assign S_we_ram[CH0_LSB]                          = w_we;
    assign S_we_ram[CH1_IDX]                          = CH1_FILL;
    assign S_addr_ram[CH0_LSB +: ADDR_W]              = w_addr;
    assign S_addr_ram[CH1_IDX*ADDR_W +: ADDR_W]       = {ADDR_W{CH1_FILL}};
    assign S_Wdata_ram[CH0_LSB +: DATA_W]             = w_wdata;
    assign S_Wdata_ram[CH1_IDX*DATA_W +: DATA_W]      = {DATA_W{CH1_FILL}};
    assign S_data_ram_size[CH0_LSB +: SIZE_W]         = w_size;
    assign S_data_ram_size[CH1_IDX*SIZE_W +: SIZE_W]  = {SIZE_W{CH1_FILL}};

endmodule

// File: tb/tb_hls_run_ctrl.sv
// tb_hls_run_ctrl: scenario tasks with a scoreboard of expected run lengths
// and read data, plus a one-cycle-latency slave RAM model on channel 0.
module tb_hls_run_ctrl;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 4;
    localparam int CNT_W  = 32;

    logic                clock;
    logic                reset;
    logic                cmd_valid;
    logic [CNT_W-1:0]    cmd_limit;
    logic                cmd_ready;
    logic                run_ok;
    logic                run_to;
    logic [CNT_W-1:0]    cycles;
    logic                start_port;
    logic                done_port;
    logic [1:0]          S_oe_ram;
    logic [1:0]          S_we_ram;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram;
    logic [2*SIZE_W-1:0] S_data_ram_size;
    logic [2*DATA_W-1:0] Sout_Rdata_ram = '0;
    logic [1:0]          Sout_DataRdy = '0;
    logic                ld_req, ld_we;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_wdata;
    logic [SIZE_W-1:0]   ld_size;
    logic                ld_rdy;
    logic [DATA_W-1:0]   ld_rdata;
    logic                rb_req, rb_we;
    logic [ADDR_W-1:0]   rb_addr;
    logic [DATA_W-1:0]   rb_wdata;
    logic [SIZE_W-1:0]   rb_size;
    logic                rb_rdy;
    logic [DATA_W-1:0]   rb_rdata;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int exp_cyc_q[$];
    logic [7:0] exp_rd_q[$];
    int exp_i;
    logic [7:0] exp_b;

    logic [7:0]   mem [128];
    logic [127:0] wr_v = '0;

    hls_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_limit(cmd_limit), .cmd_ready(cmd_ready),
        .run_ok(run_ok), .run_to(run_to), .cycles(cycles),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_size(ld_size),
        .ld_rdy(ld_rdy), .ld_rdata(ld_rdata),
        .rb_req(rb_req), .rb_we(rb_we), .rb_addr(rb_addr),
        .rb_wdata(rb_wdata), .rb_size(rb_size),
        .rb_rdy(rb_rdy), .rb_rdata(rb_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] dflt(input int a);
        logic [31:0] v;
        if (a == 5) return 8'hA5;
        v = a * 3 + 1;
        return v[7:0];
    endfunction

    function automatic logic [7:0] rd_model(input int a);
        if (wr_v[a]) return mem[a];
        return dflt(a);
    endfunction

    // slave RAM: request seen in the grant cycle, answered the next cycle
    always @(posedge clock) begin
        Sout_DataRdy   <= {1'b0, S_oe_ram[0] | S_we_ram[0]};
        Sout_Rdata_ram <= {8'h00, rd_model(int'(S_addr_ram[6:0]))};
        if (S_we_ram[0]) begin
            mem[S_addr_ram[6:0]]  <= S_Wdata_ram[7:0];
            wr_v[S_addr_ram[6:0]] <= 1'b1;
        end
    end

    always @(posedge clock) if (start_port) n_start++;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic launch(input logic [CNT_W-1:0] lim);
        cmd_limit = lim;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({cmd_ready, run_ok, run_to, start_port, ld_rdy, rb_rdy} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=100000",
                     {cmd_ready, run_ok, run_to, start_port, ld_rdy, rb_rdy});
        end
        checks++;
        if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) begin
            failures++;
            $display("FAIL reset_S got=%h exp=0",
                     {S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size});
        end
        checks++;
        if ({cycles, ld_rdata, rb_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {cycles, ld_rdata, rb_rdata});
        end
        reset = 1'b1;
        tick();
        launch(0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, start_port, cycles} !== {2'b10, 32'd0}) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=%h",
                     {cmd_ready, start_port, cycles}, {2'b10, 32'd0});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        bit seen;
        n_start = 0;
        exp_cyc_q.push_back(11);
        launch(100);
        checks++;
        if (start_port !== 1'b1) begin
            failures++;
            $display("FAIL normal_start got=%b exp=1", start_port);
        end
        repeat (10) tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (run_ok) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL normal_run_ok got=0 exp=1");
        end
        exp_i = exp_cyc_q.pop_front();
        checks++;
        if (cycles !== exp_i) begin
            failures++;
            $display("FAIL normal_cycles got=%0d exp=%0d", cycles, exp_i);
        end
        checks++;
        if ({cmd_ready, run_to} !== 2'b10) begin
            failures++;
            $display("FAIL normal_done_ready got=%b exp=10", {cmd_ready, run_to});
        end
        tick();
        checks++;
        if ({run_ok, n_start} !== {1'b0, 32'd1}) begin
            failures++;
            $display("FAIL normal_pulses got=%b/%0d exp=0/1", run_ok, n_start);
        end
    endtask

    task automatic test_done_in_start();
        exp_cyc_q.push_back(1);
        launch(100);
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        exp_i = exp_cyc_q.pop_front();
        checks++;
        if ({run_ok, run_to, cycles} !== {2'b10, exp_i[31:0]}) begin
            failures++;
            $display("FAIL done_in_start got=%b%b/%0d exp=10/%0d",
                     run_ok, run_to, cycles, exp_i);
        end
    endtask

    task automatic test_done_at_limit();
        exp_cyc_q.push_back(5);
        launch(5);
        repeat (4) tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        exp_i = exp_cyc_q.pop_front();
        checks++;
        if ({run_ok, run_to, cmd_ready, cycles} !== {3'b101, exp_i[31:0]}) begin
            failures++;
            $display("FAIL done_at_limit got=%b%b%b/%0d exp=101/%0d",
                     run_ok, run_to, cmd_ready, cycles, exp_i);
        end
        tick();
    endtask

    task automatic test_arb_priority();
        bit seen;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 7'd5; ld_size = 4'd8;
        rb_req = 1'b1; rb_we = 1'b0; rb_addr = 7'd9; rb_size = 4'd8;
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(dflt(9));
        tick();
        checks++;
        if ({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size} !==
            {2'b01, 2'b00, 14'd5, 8'h08}) begin
            failures++;
            $display("FAIL prio_ld_grant got=%b %b %h %h exp=01 00 0005 08",
                     S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ld_rdy) begin seen = 1; break; end
            tick();
        end
        exp_b = exp_rd_q.pop_front();
        checks++;
        if (!seen || ld_rdata !== exp_b || rb_rdy !== 1'b0) begin
            failures++;
            $display("FAIL prio_ld_rdata got=%b/%h exp=1/%h", seen, ld_rdata, exp_b);
        end
        ld_req = 1'b0;
        tick();
        checks++;
        if ({S_oe_ram, S_addr_ram} !== {2'b01, 14'd9}) begin
            failures++;
            $display("FAIL prio_rb_grant got=%b %h exp=01 0009", S_oe_ram, S_addr_ram);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rb_rdy) begin seen = 1; break; end
            tick();
        end
        exp_b = exp_rd_q.pop_front();
        checks++;
        if (!seen || rb_rdata !== exp_b) begin
            failures++;
            $display("FAIL prio_rb_rdata got=%b/%h exp=1/%h", seen, rb_rdata, exp_b);
        end
        rb_req = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 7'd20; ld_wdata = 8'h3C;
        tick();
        checks++;
        if ({S_oe_ram, S_we_ram, S_Wdata_ram} !== {2'b00, 2'b01, 16'h003C}) begin
            failures++;
            $display("FAIL ld_write_grant got=%b %b %h exp=00 01 003c",
                     S_oe_ram, S_we_ram, S_Wdata_ram);
        end
        for (int i = 0; i < 10; i++) begin
            if (ld_rdy) break;
            tick();
        end
        ld_req = 1'b0; ld_we = 1'b0;
        exp_rd_q.push_back(8'h3C);
        rb_req = 1'b1; rb_addr = 7'd20;
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rb_rdy) begin seen = 1; break; end
            tick();
        end
        exp_b = exp_rd_q.pop_front();
        checks++;
        if (!seen || rb_rdata !== exp_b) begin
            failures++;
            $display("FAIL rb_readback got=%b/%h exp=1/%h", seen, rb_rdata, exp_b);
        end
        rb_req = 1'b0;
        tick();
    endtask

    task automatic test_rb_during_run();
        bit act;
        bit seen;
        exp_cyc_q.push_back(8);
        launch(0);
        tick();
        rb_req = 1'b1; rb_we = 1'b0; rb_addr = 7'd33;
        exp_rd_q.push_back(dflt(33));
        act = 0;
        for (int i = 0; i < 6; i++) begin
            act |= |{S_oe_ram, S_we_ram};
            tick();
        end
        done_port = 1'b1;
        act |= |{S_oe_ram, S_we_ram};
        tick();
        done_port = 1'b0;
        act |= |{S_oe_ram, S_we_ram};
        checks++;
        if (act !== 1'b0) begin
            failures++;
            $display("FAIL run_blocks_arb got=1 exp=0");
        end
        exp_i = exp_cyc_q.pop_front();
        checks++;
        if ({run_ok, cycles} !== {1'b1, exp_i[31:0]}) begin
            failures++;
            $display("FAIL run_rb_cycles got=%b/%0d exp=1/%0d", run_ok, cycles, exp_i);
        end
        tick();
        checks++;
        if ({S_oe_ram, S_addr_ram} !== {2'b01, 14'd33}) begin
            failures++;
            $display("FAIL run_rb_grant got=%b %h exp=01 0021", S_oe_ram, S_addr_ram);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rb_rdy) begin seen = 1; break; end
            tick();
        end
        exp_b = exp_rd_q.pop_front();
        checks++;
        if (!seen || rb_rdata !== exp_b) begin
            failures++;
            $display("FAIL run_rb_rdata got=%b/%h exp=1/%h", seen, rb_rdata, exp_b);
        end
        rb_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        bit ok_seen;
        bit rdy_seen;
        n_start = 0;
        exp_cyc_q.push_back(50);
        launch(50);
        seen = 0;
        ok_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (run_to) begin seen = 1; break; end
            ok_seen |= run_ok;
            tick();
        end
        exp_i = exp_cyc_q.pop_front();
        checks++;
        if (!seen || ok_seen || cycles !== exp_i) begin
            failures++;
            $display("FAIL timeout got=%b%b/%0d exp=10/%0d", seen, ok_seen, cycles, exp_i);
        end
        cmd_limit = 100;
        cmd_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            seen |= cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (seen || n_start != 1 || run_to !== 1'b1) begin
            failures++;
            $display("FAIL timeout_stuck got=%b/%0d/%b exp=0/1/1", seen, n_start, run_to);
        end
        exp_rd_q.push_back(8'hA5);
        rb_req = 1'b1; rb_addr = 7'd5;
        tick();
        checks++;
        if ({S_oe_ram, S_addr_ram} !== {2'b01, 14'd5}) begin
            failures++;
            $display("FAIL timeout_rb_grant got=%b %h exp=01 0005", S_oe_ram, S_addr_ram);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rb_rdy) begin seen = 1; break; end
            tick();
        end
        exp_b = exp_rd_q.pop_front();
        checks++;
        if (!seen || rb_rdata !== exp_b) begin
            failures++;
            $display("FAIL timeout_rb_rdata got=%b/%h exp=1/%h", seen, rb_rdata, exp_b);
        end
        rb_req = 1'b0;
        tick();
        rb_req = 1'b1; rb_addr = 7'd7;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, run_to, rb_rdy, S_oe_ram, cycles, rb_rdata} !==
            {3'b100, 2'b00, 32'd0, 8'd0}) begin
            failures++;
            $display("FAIL reset_mid_acc got=%b%b%b %b %0d %h exp=100 00 0 00",
                     cmd_ready, run_to, rb_rdy, S_oe_ram, cycles, rb_rdata);
        end
        rb_req = 1'b0;
        rdy_seen = 0;
        tick();
        rdy_seen |= rb_rdy;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdy_seen |= rb_rdy | ld_rdy;
            tick();
        end
        checks++;
        if (rdy_seen || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_drops_acc got=%b/%b exp=0/1", rdy_seen, cmd_ready);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_limit = '0; done_port = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_size = '0;
        rb_req = 1'b0; rb_we = 1'b0; rb_addr = '0; rb_wdata = '0; rb_size = '0;
        test_reset();
        test_normal();
        test_done_in_start();
        test_done_at_limit();
        test_arb_priority();
        test_rb_during_run();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
